// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_types_pkg                                                        |
// | Shared opcode enum, encoder error codes and range helper.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

  typedef enum logic [6:0] {
    RTYPE = 7'b0110011,
    ITYPE = 7'b0010011,
    LW    = 7'b0000011,
    STYPE = 7'b0100011,
    BTYPE = 7'b1100011,
    JAL   = 7'b1101111,
    JALR  = 7'b1100111,
    LUI   = 7'b0110111,
    AUIPC = 7'b0010111
  } opcode_t;

  typedef enum logic [1:0] {
    ENC_OK      = 2'b00,
    ENC_RANGE   = 2'b01,
    ENC_ALIGN   = 2'b10,
    ENC_ILLEGAL = 2'b11
  } enc_err_t;

  localparam int FIFO_DEPTH = 2;

  function automatic logic in_srange(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_encoder_if                                                      |
// | Request/response bus of the instruction encoder.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] enc_count;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, err, err_code, enc_count
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, err, err_code, enc_count
  );
endinterface
`default_nettype wire

// File: rtl/imm_encode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_encode                                                           |
// | Packs instruction fields into a word and flags range/align errors.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_encode
  import cpu_types_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output enc_err_t    err_o
);

  always_comb begin
    inst_o = '0;
    err_o  = ENC_OK;
    case (opcode_i)
      RTYPE: inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      ITYPE, LW, JALR: begin
        inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!in_srange(imm_i, -2048, 2047)) err_o = ENC_RANGE;
      end
      STYPE: begin
        inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!in_srange(imm_i, -2048, 2047)) err_o = ENC_RANGE;
      end
      BTYPE: begin
        inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        // Range is judged before alignment so an odd out-of-range offset reports RANGE
        if (!in_srange(imm_i, -4096, 4094)) err_o = ENC_RANGE;
        else if (imm_i[0])                  err_o = ENC_ALIGN;
      end
      JAL: begin
        inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (!in_srange(imm_i, -1048576, 1048574)) err_o = ENC_RANGE;
        else if (imm_i[0])                        err_o = ENC_ALIGN;
      end
      LUI, AUIPC: begin
        inst_o = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'd0) err_o = ENC_ALIGN;
      end
      default: err_o = ENC_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_encoder                                                         |
// | Accepts field sets, encodes them into a 2-entry output FIFO.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inst_encoder
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  inst_encoder_if.slave bus
);

  logic [31:0] enc_word;
  enc_err_t    enc_err;

  imm_encode u_imm_encode (
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .inst_o   (enc_word),
    .err_o    (enc_err)
  );

  logic [31:0] mem_q [FIFO_DEPTH];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        err_q, err_d;
  enc_err_t    err_code_q, err_code_d;
  logic [15:0] enc_count_q, enc_count_d;

  logic accept, push, pop;

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_inst  = mem_q[rd_ptr_q];
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.enc_count = enc_count_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && (enc_err == ENC_OK);
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    enc_count_d = enc_count_q;
    if (accept && (enc_err != ENC_OK)) begin
      err_d      = 1'b1;
      err_code_d = enc_err;
    end
    if (push) begin
      wr_ptr_d    = ~wr_ptr_q;
      enc_count_d = enc_count_q + 16'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      err_q       <= 1'b0;
      err_code_q  <= ENC_OK;
      enc_count_q <= 16'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= enc_word;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      enc_count_q <= enc_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_encoder                                                      |
// | Directed and random checks of inst_encoder against a queue model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_inst_encoder;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  inst_encoder_if bus_if ();

  inst_encoder u_dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;
  logic        exp_err   = 1'b0;
  logic [1:0]  exp_code  = 2'd0;

  logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [31:0] edge_imms [12] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
                                  -32'sd4096, -32'sd4098, 32'd1048574, -32'sd1048576, 32'd1048576,
                                  32'h12345000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from the per-format bit placement rules
  function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm, output logic [31:0] w, output logic [1:0] c);
    int s;
    logic [31:0] base;
    s    = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w = 32'd0;
    c = 2'd0;
    case (op)
      7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      7'h13, 7'h03, 7'h67: begin
        w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
        if (s < -2048 || s > 2047) c = 2'd1;
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
        if (s < -2048 || s > 2047) c = 2'd1;
      end
      7'h63: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        if (s < -4096 || s > 4094) c = 2'd1;
        else if (s % 2 != 0)       c = 2'd2;
      end
      7'h6F: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
        if (s < -1048576 || s > 1048574) c = 2'd1;
        else if (s % 2 != 0)             c = 2'd2;
      end
      7'h37, 7'h17: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        if ((imm & 32'hFFF) != 0) c = 2'd2;
      end
      default: c = 2'd3;
    endcase
  endfunction

  task automatic req(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    bus_if.in_valid  = v;
    bus_if.in_opcode = op;
    bus_if.in_rd     = rd;
    bus_if.in_rs1    = rs1;
    bus_if.in_rs2    = rs2;
    bus_if.in_funct3 = f3;
    bus_if.in_funct7 = f7;
    bus_if.in_imm    = imm;
  endtask

  task automatic idle();
    req(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
  endtask

  // One clock: check pre-edge outputs, advance model and DUT, check post-edge status
  task automatic step();
    logic [31:0] w;
    logic [1:0]  c;
    logic        acc, pop;
    chk("in_ready", bus_if.in_ready, 32'(exp_q.size() < 2));
    chk("out_valid", bus_if.out_valid, 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_inst", bus_if.out_inst, exp_q[0]);
    acc = bus_if.in_valid && (exp_q.size() < 2);
    pop = bus_if.out_ready && (exp_q.size() != 0);
    ref_enc(bus_if.in_opcode, bus_if.in_rd, bus_if.in_rs1, bus_if.in_rs2,
            bus_if.in_funct3, bus_if.in_funct7, bus_if.in_imm, w, c);
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    exp_err = 1'b0;
    if (acc) begin
      if (c == 2'd0) begin
        exp_q.push_back(w);
        exp_count = exp_count + 16'd1;
      end else begin
        exp_err  = 1'b1;
        exp_code = c;
      end
    end
    chk("err", bus_if.err, 32'(exp_err));
    chk("err_code", bus_if.err_code, 32'(exp_code));
    chk("enc_count", bus_if.enc_count, 32'(exp_count));
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    bus_if.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", bus_if.out_valid, 32'd0);
    chk("rst_out_inst", bus_if.out_inst, 32'd0);
    chk("rst_err", bus_if.err, 32'd0);
    chk("rst_err_code", bus_if.err_code, 32'd0);
    chk("rst_enc_count", bus_if.enc_count, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus_if.in_ready, 32'd1);

    // Directed golden encodings
    bus_if.out_ready = 1'b1;
    req(1'b1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    step();
    chk("itype_word", bus_if.out_inst, 32'hFFF00093);
    chk("itype_count", bus_if.enc_count, 32'd1);
    req(1'b1, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    step();
    chk("btype_word", bus_if.out_inst, 32'hFE000EE3);
    req(1'b1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    chk("stype_word", bus_if.out_inst, 32'h0020A423);
    req(1'b1, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    step();
    chk("jal_word", bus_if.out_inst, 32'h001000EF);
    req(1'b1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    step();
    chk("lui_word", bus_if.out_inst, 32'h123452B7);
    idle();
    step();

    // Rejected requests
    req(1'b1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    chk("range_err", bus_if.err, 32'd1);
    chk("range_code", bus_if.err_code, 32'd1);
    idle();
    step();
    chk("err_pulse_end", bus_if.err, 32'd0);
    chk("err_code_hold", bus_if.err_code, 32'd1);
    req(1'b1, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    step();
    chk("align_code", bus_if.err_code, 32'd2);
    req(1'b1, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    chk("illegal_code", bus_if.err_code, 32'd3);
    chk("illegal_no_valid", bus_if.out_valid, 32'd0);
    chk("err_count_same", bus_if.enc_count, 32'd5);
    idle();
    step();

    // Back-pressure: third request held while FIFO is full
    bus_if.out_ready = 1'b0;
    req(1'b1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    req(1'b1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    step();
    chk("full_ready", bus_if.in_ready, 32'd0);
    req(1'b1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    step();
    chk("held_ready", bus_if.in_ready, 32'd0);
    chk("held_head", bus_if.out_inst, 32'h00500113);
    bus_if.out_ready = 1'b1;
    step();
    chk("drain_second", bus_if.out_inst, 32'h00600193);
    step();
    chk("drain_third", bus_if.out_inst, 32'h00700213);
    chk("bp_count", bus_if.enc_count, 32'd8);
    idle();
    step();
    chk("drained", bus_if.out_valid, 32'd0);

    // Asynchronous reset with two words buffered
    bus_if.out_ready = 1'b0;
    req(1'b1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    req(1'b1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    step();
    idle();
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", bus_if.out_valid, 32'd0);
    chk("mid_rst_count", bus_if.enc_count, 32'd0);
    chk("mid_rst_inst", bus_if.out_inst, 32'd0);
    exp_q.delete();
    exp_count = 16'd0;
    exp_err   = 1'b0;
    exp_code  = 2'd0;
    @(negedge clk);
    nrst = 1'b1;
    bus_if.out_ready = 1'b1;
    step();
    chk("post_rst_valid", bus_if.out_valid, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] imm;
      logic [6:0]  op;
      int          t;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: begin t = int'($urandom_range(0, 10000)) - 5000; imm = t; end
        2: imm = edge_imms[$urandom_range(0, 11)];
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      req($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), imm);
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    bus_if.out_ready = 1'b1;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
